// File: rtl/mic1_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mic1_mem_ctrl
// Brief    : MIC-1 initiator-side memory controller. Owns MAR/MDR/PC/MBR and
//            turns rd/wr/fetch strobes into port-A word and port-B byte requests.
// Option   : define MEM_BOUNDS_CHECK_EN to trap accesses beyond MEMORY_SIZE.
// Revision : 1.0 - initial release
// ============================================================================
module mic1_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MEMORY_SIZE = 'h0083
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       c_bus,
  input  logic              mar_ld,
  input  logic              mdr_ld,
  input  logic              pc_ld,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  output logic [31:0]       mar,
  output logic [31:0]       mdr,
  output logic [31:0]       pc,
  output logic [31:0]       mbr,
  output logic [31:0]       mbru,
  output logic [ADDR_W-1:0] addr_A,
  output logic [31:0]       wdata_A,
  output logic              wen_A,
  output logic              ren_A,
  input  logic [31:0]       rdata_A,
  output logic [ADDR_W-1:0] addr_B,
  output logic              ren_B,
  input  logic [7:0]        rdata_B,
  output logic              busy,
  output logic              conflict
);

  logic [31:0]       mar_q, mar_d, mdr_q, mdr_d, pc_q, pc_d, wdata_a_q, wdata_a_d;
  logic [7:0]        mbr_q, mbr_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic              wen_a_q, wen_a_d, ren_a_q, ren_a_d, ren_b_q, ren_b_d;
  logic              rd_oob_q, rd_oob_d, fetch_oob_q, fetch_oob_d;
  logic              conflict_q, conflict_d;
  logic              mar_oob, pc_oob;

`ifdef MEM_BOUNDS_CHECK_EN
  assign mar_oob = (mar_q >= 32'(MEMORY_SIZE));
  assign pc_oob  = ((pc_q >> 2) >= 32'(MEMORY_SIZE));
`else
  logic unused_memory_size;
  assign unused_memory_size = ^32'(MEMORY_SIZE);
  assign mar_oob = 1'b0;
  assign pc_oob  = 1'b0;
`endif

  always_comb begin
    mar_d       = mar_ld ? c_bus : mar_q;
    pc_d        = pc_ld  ? c_bus : pc_q;
    conflict_d  = conflict_q;

    // Requests snapshot MAR/MDR/PC before any load landing on the same edge.
    addr_a_d    = addr_a_q;
    wdata_a_d   = wdata_a_q;
    wen_a_d     = 1'b0;
    ren_a_d     = 1'b0;
    rd_oob_d    = 1'b0;
    if (rd | wr) begin
      addr_a_d  = mar_q[ADDR_W-1:0];
      wdata_a_d = mdr_q;
      wen_a_d   = wr & ~mar_oob;
      ren_a_d   = rd & ~wr & ~mar_oob;
      rd_oob_d  = rd & ~wr & mar_oob;
      if ((rd & wr) | mar_oob) conflict_d = 1'b1;
    end

    addr_b_d    = addr_b_q;
    ren_b_d     = 1'b0;
    fetch_oob_d = 1'b0;
    if (fetch) begin
      addr_b_d    = pc_q[ADDR_W-1:0];
      ren_b_d     = ~pc_oob;
      fetch_oob_d = pc_oob;
      if (pc_oob) conflict_d = 1'b1;
    end

    // Returning memory data outranks a datapath load of MDR.
    if (ren_a_q)       mdr_d = rdata_A;
    else if (rd_oob_q) mdr_d = 32'hDEAD_BEEF;
    else if (mdr_ld)   mdr_d = c_bus;
    else               mdr_d = mdr_q;
    if ((ren_a_q | rd_oob_q) & mdr_ld) conflict_d = 1'b1;

    if (ren_b_q)          mbr_d = rdata_B;
    else if (fetch_oob_q) mbr_d = 8'hFF;
    else                  mbr_d = mbr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_q       <= '0;
      mdr_q       <= '0;
      pc_q        <= '0;
      mbr_q       <= '0;
      addr_a_q    <= '0;
      wdata_a_q   <= '0;
      wen_a_q     <= 1'b0;
      ren_a_q     <= 1'b0;
      rd_oob_q    <= 1'b0;
      addr_b_q    <= '0;
      ren_b_q     <= 1'b0;
      fetch_oob_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      pc_q        <= pc_d;
      mbr_q       <= mbr_d;
      addr_a_q    <= addr_a_d;
      wdata_a_q   <= wdata_a_d;
      wen_a_q     <= wen_a_d;
      ren_a_q     <= ren_a_d;
      rd_oob_q    <= rd_oob_d;
      addr_b_q    <= addr_b_d;
      ren_b_q     <= ren_b_d;
      fetch_oob_q <= fetch_oob_d;
      conflict_q  <= conflict_d;
    end
  end

  assign mar      = mar_q;
  assign mdr      = mdr_q;
  assign pc       = pc_q;
  assign mbr      = {{24{mbr_q[7]}}, mbr_q};
  assign mbru     = {24'h0, mbr_q};
  assign addr_A   = addr_a_q;
  assign wdata_A  = wdata_a_q;
  assign wen_A    = wen_a_q;
  assign ren_A    = ren_a_q;
  assign addr_B   = addr_b_q;
  assign ren_B    = ren_b_q;
  assign busy     = ren_a_q | wen_a_q | ren_b_q;
  assign conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_mic1_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic1_mem_ctrl
// Brief    : Scoreboard bench for mic1_mem_ctrl with a negedge memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic1_mem_ctrl;
  localparam int ADDR_W = 32;
  localparam logic [5:0] MAR_LD = 6'b100000, MDR_LD = 6'b010000, PC_LD = 6'b001000;
  localparam logic [5:0] RD = 6'b000100, WR = 6'b000010, FETCH = 6'b000001, IDLE = 6'b000000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       c_bus = '0;
  logic              mar_ld = 0, mdr_ld = 0, pc_ld = 0, rd = 0, wr = 0, fetch = 0;
  logic [31:0]       mar, mdr, pc, mbr, mbru, wdata_A;
  logic [ADDR_W-1:0] addr_A, addr_B;
  logic              wen_A, ren_A, ren_B, busy, conflict;
  logic [31:0]       rdata_A = '0;
  logic [7:0]        rdata_B = '0;

  mic1_mem_ctrl #(.ADDR_W(ADDR_W), .MEMORY_SIZE('h0083)) dut (
    .clk(clk), .rst(rst), .c_bus(c_bus),
    .mar_ld(mar_ld), .mdr_ld(mdr_ld), .pc_ld(pc_ld),
    .rd(rd), .wr(wr), .fetch(fetch),
    .mar(mar), .mdr(mdr), .pc(pc), .mbr(mbr), .mbru(mbru),
    .addr_A(addr_A), .wdata_A(wdata_A), .wen_A(wen_A), .ren_A(ren_A), .rdata_A(rdata_A),
    .addr_B(addr_B), .ren_B(ren_B), .rdata_B(rdata_B),
    .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } a_req_t;
  typedef struct { logic [31:0] addr; logic [31:0] s; logic [31:0] u; } b_req_t;

  a_req_t      exp_a[$];
  logic [31:0] exp_mdr[$];
  b_req_t      exp_b[$];
  a_req_t      ea;
  b_req_t      eb;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [0:255];
  logic        prev_ren_a = 1'b0;
  logic        prev_ren_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [5:0] ctl, input logic [31:0] cb);
    {mar_ld, mdr_ld, pc_ld, rd, wr, fetch} = ctl;
    c_bus = cb;
    @(posedge clk); #1;
    {mar_ld, mdr_ld, pc_ld, rd, wr, fetch} = IDLE;
    c_bus = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_a(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_a.push_back('{w, a, d});
  endtask

  task automatic push_b(input logic [31:0] a, input logic [31:0] s, input logic [31:0] u);
    exp_b.push_back('{a, s, u});
  endtask

  // Memory: samples requests and drives data on the falling edge, little-endian bytes.
  always @(negedge clk) begin
    if (wen_A) mem[addr_A[7:0]] = wdata_A;
    if (ren_A) rdata_A = mem[addr_A[7:0]];
    if (ren_B) rdata_B = 8'(mem[addr_B[9:2]] >> (8 * addr_B[1:0]));
  end

  // Scoreboard monitor: requests checked in their cycle, returns one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      prev_ren_a <= 1'b0;
      prev_ren_b <= 1'b0;
    end else begin
      if (prev_ren_a) begin
        check("mdr_pending", 32'(exp_mdr.size() != 0), 32'd1);
        if (exp_mdr.size() != 0) check("mdr", mdr, exp_mdr.pop_front());
      end
      if (prev_ren_b) begin
        check("mbr_pending", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          check("mbr", mbr, eb.s);
          check("mbru", mbru, eb.u);
        end
      end
      if (wen_A | ren_A) begin
        check("a_pending", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          ea = exp_a.pop_front();
          check("a_kind", 32'({wen_A, ren_A}), 32'({ea.wr, ~ea.wr}));
          check("addr_A", 32'(addr_A), ea.addr);
          if (ea.wr) check("wdata_A", wdata_A, ea.data);
          check("busy_a", 32'(busy), 32'd1);
        end
      end
      if (ren_B) begin
        check("b_pending", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) check("addr_B", 32'(addr_B), exp_b[0].addr);
        check("busy_b", 32'(busy), 32'd1);
      end
      prev_ren_a <= ren_A;
      prev_ren_b <= ren_B;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1]     = 32'h80FF_7F01;
    mem[2]     = 32'h0000_0022;
    mem[3]     = 32'h1234_5678;
    mem[5]     = 32'hCAFE_0005;
    mem[8'h83] = 32'h5A5A_0083;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mar", mar, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_mbr", mbr, 32'h0);
    check("rst_mbru", mbru, 32'h0);
    check("rst_addr_A", 32'(addr_A), 32'h0);
    check("rst_addr_B", 32'(addr_B), 32'h0);
    check("rst_wdata_A", wdata_A, 32'h0);
    check("rst_enables", 32'({wen_A, ren_A, ren_B}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);

    // Reset while a read is in flight drops it
    step(MAR_LD, 32'd5);
    step(RD, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ren_A", 32'(ren_A), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("midrst_mdr", mdr, 32'h0);
    check("midrst_mar", mar, 32'h0);
    check("midrst_conflict", 32'(conflict), 32'h0);

    // Word read
    step(MAR_LD, 32'd3);
    push_a(1'b0, 32'd3, 32'h0);
    exp_mdr.push_back(32'h1234_5678);
    step(RD, 32'h0);
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);

    // Write then read back; MDR is cleared in the rd cycle so the return is visible
    step(MAR_LD, 32'd7);
    step(MDR_LD, 32'hA5A5_A5A5);
    push_a(1'b1, 32'd7, 32'hA5A5_A5A5);
    step(WR, 32'h0);
    push_a(1'b0, 32'd7, 32'h0);
    exp_mdr.push_back(32'hA5A5_A5A5);
    step(RD | MDR_LD, 32'h0);
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);

    // Back-to-back fetches with sign/zero extension; PC loads use pre-load snapshot
    step(PC_LD, 32'd4);
    push_b(32'd4, 32'h0000_0001, 32'h0000_0001);
    step(FETCH | PC_LD, 32'd5);
    push_b(32'd5, 32'h0000_007F, 32'h0000_007F);
    step(FETCH | PC_LD, 32'd6);
    push_b(32'd6, 32'hFFFF_FFFF, 32'h0000_00FF);
    step(FETCH | PC_LD, 32'd7);
    push_b(32'd7, 32'hFFFF_FF80, 32'h0000_0080);
    step(FETCH, 32'h0);
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("no_conflict_yet", 32'(conflict), 32'h0);

    // rd & wr together: write only, conflict set
    step(MAR_LD, 32'd9);
    step(MDR_LD, 32'hBEEF_0009);
    push_a(1'b1, 32'd9, 32'hBEEF_0009);
    step(RD | WR, 32'h0);
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("rdwr_conflict", 32'(conflict), 32'h1);
    check("rdwr_mem9", mem[9], 32'hBEEF_0009);
    check("rdwr_mdr", mdr, 32'hBEEF_0009);

    // mdr_ld colliding with a read return: memory wins
    do_reset();
    @(negedge clk);
    check("reset_clears_conflict", 32'(conflict), 32'h0);
    step(MAR_LD, 32'd2);
    push_a(1'b0, 32'd2, 32'h0);
    exp_mdr.push_back(32'h0000_0022);
    step(RD, 32'h0);
    step(MDR_LD, 32'h0000_0011);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("mdrld_conflict", 32'(conflict), 32'h1);

    // Out-of-range accesses
    do_reset();
    step(MAR_LD, 32'h83);
`ifdef MEM_BOUNDS_CHECK_EN
    step(RD, 32'h0);
    @(negedge clk);
    check("oob_ren_A", 32'(ren_A), 32'h0);
    check("oob_busy", 32'(busy), 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("oob_mdr", mdr, 32'hDEAD_BEEF);
    check("oob_conflict", 32'(conflict), 32'h1);
    do_reset();
    step(PC_LD, 32'h20C);
    step(FETCH, 32'h0);
    @(negedge clk);
    check("oob_ren_B", 32'(ren_B), 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("oob_mbr", mbr, 32'hFFFF_FFFF);
    check("oob_mbru", mbru, 32'h0000_00FF);
    check("oob_fetch_conflict", 32'(conflict), 32'h1);
`else
    push_a(1'b0, 32'h83, 32'h0);
    exp_mdr.push_back(32'h5A5A_0083);
    step(RD, 32'h0);
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);
    step(PC_LD, 32'h20C);
    push_b(32'h20C, 32'hFFFF_FF83, 32'h0000_0083);
    step(FETCH, 32'h0);
    step(IDLE, 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("no_bounds_conflict", 32'(conflict), 32'h0);
`endif

    step(IDLE, 32'h0);
    step(IDLE, 32'h0);
    @(negedge clk);
    check("drain_a", 32'(exp_a.size()), 32'h0);
    check("drain_mdr", 32'(exp_mdr.size()), 32'h0);
    check("drain_b", 32'(exp_b.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mic1_mem_ctrl.md
Name: mic1_mem_ctrl

Overview:
- Initiator-side memory controller for the MIC-1 datapath. It owns the MAR, MDR, PC and MBR registers.
- It converts per-microinstruction rd/wr/fetch strobes into port-A (word read/write) and port-B (byte fetch) requests to main memory.
- It captures the returned data into MDR/MBR with the MIC-1 two-cycle read semantics.
- Main memory samples requests and produces data on the falling clock edge. This block registers everything on the rising edge.

Parameters:
- ADDR_W, 32, width of MAR/PC and of the memory address buses.
- MEMORY_SIZE, 'h0083, number of 32-bit words implemented. Used only by the optional bounds check.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- c_bus  in  32  datapath C bus.
- mar_ld, mdr_ld, pc_ld  in  1 each  load register from c_bus at posedge.
- rd, wr, fetch  in  1 each  memory strobes from the current microinstruction.
- mar, mdr, pc  out  32 each  register contents to the B bus.
- mbr  out  32  MBR sign-extended to 32 bits.
- mbru  out  32  MBR zero-extended to 32 bits.
- addr_A  out  ADDR_W  word address to memory port A.
- wdata_A  out  32  write data to port A.
- wen_A, ren_A  out  1 each  port A write and read enables.
- rdata_A  in  32  port A read data, valid after the negedge on which ren_A is high.
- addr_B  out  ADDR_W  byte address to port B.
- ren_B  out  1  port B read enable.
- rdata_B  in  8  port B byte; must see addr_B held stable until MBR captures it.
- busy  out  1  a request is in flight.
- conflict  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async): mar=mdr=pc=0, mbr byte=0, addr_A=addr_B=wdata_A=0, wen_A=ren_A=ren_B=0, busy=0, conflict=0, all pipeline state cleared. A request in flight is dropped and produces no MDR/MBR update.
- Register loads: mar_ld/mdr_ld/pc_ld write c_bus at posedge.
- Snapshots: rd/wr/fetch take the value of MAR/MDR/PC at the same posedge. That is the value before any simultaneous *_ld, per MIC-1 timing.
- Port A request: rd or wr sampled high at posedge ending cycle N.
  - Cycle N+1: addr_A=MAR snapshot, ren_A=rd, wen_A=wr, wdata_A=MDR snapshot, all registered.
  - Memory acts on the negedge inside cycle N+1.
  - For a read, MDR captures rdata_A at the posedge ending N+1, so the new MDR is visible in cycle N+2.
  - Enables are high for exactly one cycle per strobe cycle.
- Port B request: fetch sampled high ending cycle N.
  - Cycle N+1: addr_B=PC snapshot and ren_B=1.
  - MBR captures rdata_B at the posedge ending N+1.
  - addr_B holds its value until the next fetch.
- Strobe rules:
  - Back-to-back strobes in consecutive cycles are legal and fully pipelined, one request per cycle per port.
  - rd and wr may not be high together. If both are high: the write proceeds, the read is suppressed, and conflict is set.
  - fetch is independent of rd/wr and may coincide with either.
- MDR priority: if a read return and mdr_ld hit the same posedge, the memory data wins and conflict is set. MBR has no datapath load, so it has no equivalent conflict.
- busy = ren_A | wen_A | ren_B, in the registered request cycle.
- conflict is sticky and clears only on reset.
- mbr = {{24{b[7]}}, b}; mbru = {24'h0, b}.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- When defined, a port-A request whose MAR snapshot is >= MEMORY_SIZE behaves as follows:
  - wen_A and ren_A are forced to 0.
  - A read loads MDR with 32'hDEADBEEF.
  - conflict is set.
- A fetch with (PC>>2) >= MEMORY_SIZE forces ren_B=0, loads MBR with 8'hFF, and sets conflict.
- When undefined, no address checking is done and out-of-range accesses pass straight to memory.

Test Plan:
- Reset mid-read: assert rd with MAR=5, then rst in cycle N+1 -> MDR stays 0, ren_A=0 after reset, busy=0, conflict=0.
- Word read: MAR=3, memory word 3=32'h12345678, rd in cycle 0 -> cycle 1: ren_A=1, addr_A=3; cycle 2: mdr=32'h12345678.
- Write then read back: MAR=7, MDR=32'hA5A5A5A5, wr; next cycle rd -> wen_A pulse with wdata_A=A5A5A5A5, followed by mdr=A5A5A5A5 two cycles after rd.
- Fetch with sign extension: memory word 1=32'h80FF7F01; fetch at PC=4,5,6,7 on consecutive cycles -> mbr = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80 and mbru = 0x01, 0x7F, 0xFF, 0x80.
- Conflicts: rd&wr together -> only wen_A pulses, conflict=1. Separately, mdr_ld with c_bus=0x11 landing on a read return of 0x22 -> mdr=0x22, conflict=1.
- With MEM_BOUNDS_CHECK_EN: MAR=0x83, rd -> ren_A stays 0, mdr=32'hDEADBEEF, conflict=1. Without the macro: ren_A=1 with addr_A=0x83.
